// File: rtl/traffic_inputs_pkg.sv
// Shared constants for the traffic controller input stage and the light controller.
// Default timing assumes a 100 MHz clock.
package traffic_inputs_pkg;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_TICK_CYCLES     = 100000000;
    localparam int DEF_DB_W            = 19;
    localparam int DEF_TICK_W          = 27;

    // Light encodings shared with traffic_light so both blocks agree.
    typedef enum logic [1:0] {
        LIGHT_RED    = 2'b00,
        LIGHT_YELLOW = 2'b01,
        LIGHT_GREEN  = 2'b10
    } light_e;

endpackage

// File: rtl/traffic_inputs_debouncer.sv
// Two-flop synchroniser followed by a stable-level counter.
// The output level changes only after the synchronised input has differed for DEBOUNCE_CYCLES cycles.
module traffic_inputs_debouncer
    import traffic_inputs_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int DB_W            = DEF_DB_W
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            db_q, db_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    // A sample matching the current level clears the count, so any glitch restarts it.
    always_comb begin
        sync1_d = in;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = ~db_q;
            end else begin
                cnt_d = cnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out = db_q;

endmodule

// File: rtl/traffic_inputs.sv
// Input conditioning for the traffic light controller: debounced sensor,
// sticky walk request with acknowledge, and a restartable one-second tick.
module traffic_inputs
    import traffic_inputs_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int TICK_CYCLES     = DEF_TICK_CYCLES,
    parameter int DB_W            = DEF_DB_W,
    parameter int TICK_W          = DEF_TICK_W
) (
    input  logic clk,
    input  logic rst,
    input  logic sensorIn,
    input  logic walkButtonIn,
    input  logic walkAck,
    input  logic tickRestart,
    output logic Sensor,
    output logic walkReq,
    output logic secTick
);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

    logic              btn_db;
    logic              btn_prev_q, btn_prev_d;
    logic              walk_req_q, walk_req_d;
    logic              tick_q, tick_d;
    logic [TICK_W-1:0] tcnt_q, tcnt_d;
    logic              btn_rise;

    traffic_inputs_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .DB_W           (DB_W)
    ) u_sensor_db (
        .clk(clk),
        .rst(rst),
        .in (sensorIn),
        .out(Sensor)
    );

    traffic_inputs_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .DB_W           (DB_W)
    ) u_button_db (
        .clk(clk),
        .rst(rst),
        .in (walkButtonIn),
        .out(btn_db)
    );

    assign btn_rise = btn_db & ~btn_prev_q;

    // A new press takes priority over an acknowledge so a press is never lost.
    always_comb begin
        btn_prev_d = btn_db;
        walk_req_d = walk_req_q;
        if (btn_rise) begin
            walk_req_d = 1'b1;
        end else if (walkAck) begin
            walk_req_d = 1'b0;
        end
    end

    // A restart on the terminal cycle suppresses that period's tick.
    always_comb begin
        tick_d = 1'b0;
        tcnt_d = tcnt_q + TICK_W'(1);
        if (tickRestart) begin
            tcnt_d = '0;
        end else if (tcnt_q == TICK_LAST) begin
            tcnt_d = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev_q <= 1'b0;
            walk_req_q <= 1'b0;
            tick_q     <= 1'b0;
            tcnt_q     <= '0;
        end else begin
            btn_prev_q <= btn_prev_d;
            walk_req_q <= walk_req_d;
            tick_q     <= tick_d;
            tcnt_q     <= tcnt_d;
        end
    end

    assign walkReq = walk_req_q;
    assign secTick = tick_q;

endmodule

// File: tb/tb_traffic_inputs.sv
// Directed bench for traffic_inputs with an event-schedule model checked every cycle
// plus hand-computed expectations at the interesting points.
module tb_traffic_inputs;

    localparam int DEB  = 4;
    localparam int TICK = 10;

    logic clk          = 1'b0;
    logic rst          = 1'b1;
    logic sensorIn     = 1'b0;
    logic walkButtonIn = 1'b0;
    logic walkAck      = 1'b0;
    logic tickRestart  = 1'b0;
    logic Sensor;
    logic walkReq;
    logic secTick;

    int checks   = 0;
    int failures = 0;

    traffic_inputs #(
        .DEBOUNCE_CYCLES(DEB),
        .TICK_CYCLES    (TICK),
        .DB_W           (3),
        .TICK_W         (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sensorIn    (sensorIn),
        .walkButtonIn(walkButtonIn),
        .walkAck     (walkAck),
        .tickRestart (tickRestart),
        .Sensor      (Sensor),
        .walkReq     (walkReq),
        .secTick     (secTick)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    // Behavioural model: index 0 = sensor, 1 = button.
    // Debounce: level flips once DEB consecutive synchronised samples differ from it.
    // Timebase: a schedule of the edge number at which the next tick is due.
    bit p1[2];
    bit p2[2];
    bit m_db[2];
    int run[2];
    bit raw_m[2];
    bit s_m;
    bit old_bdb;
    bit b_prev      = 1'b0;
    bit m_walk      = 1'b0;
    bit m_tick      = 1'b0;
    int edge_n      = 0;
    int next_tick   = 0;
    bit model_valid = 1'b0;

    always @(posedge clk) begin
        edge_n = edge_n + 1;
        model_valid = 1'b1;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                p1[i]   = 1'b0;
                p2[i]   = 1'b0;
                m_db[i] = 1'b0;
                run[i]  = 0;
            end
            b_prev    = 1'b0;
            m_walk    = 1'b0;
            m_tick    = 1'b0;
            next_tick = edge_n + TICK;
        end else begin
            old_bdb  = m_db[1];
            raw_m[0] = sensorIn;
            raw_m[1] = walkButtonIn;
            for (int i = 0; i < 2; i++) begin
                s_m   = p2[i];
                p2[i] = p1[i];
                p1[i] = raw_m[i];
                if (s_m == m_db[i]) begin
                    run[i] = 0;
                end else begin
                    run[i] = run[i] + 1;
                    if (run[i] == DEB) begin
                        m_db[i] = ~m_db[i];
                        run[i]  = 0;
                    end
                end
            end
            if (old_bdb && !b_prev) m_walk = 1'b1;
            else if (walkAck) m_walk = 1'b0;
            b_prev = old_bdb;
            m_tick = 1'b0;
            if (tickRestart) begin
                next_tick = edge_n + TICK;
            end else if (edge_n == next_tick) begin
                m_tick    = 1'b1;
                next_tick = edge_n + TICK;
            end
        end
    end

    task automatic check(input string name, input logic got, input logic exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    // Scoreboard: every cycle against the model
    always @(negedge clk) begin
        if (model_valid) begin
            check("model_sensor", Sensor, m_db[0]);
            check("model_walk_req", walkReq, m_walk);
            check("model_sec_tick", secTick, m_tick);
        end
    end

    // Driver tasks
    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_tick();
        bit seen = 1'b0;
        for (int k = 0; k < 3 * TICK && !seen; k++) begin
            step(1);
            if (secTick === 1'b1) seen = 1'b1;
        end
        checks = checks + 1;
        if (!seen) begin
            failures = failures + 1;
            $display("FAIL wait_tick: secTick=0 for %0d cycles, required a pulse", 3 * TICK);
        end
    endtask

    initial begin
        // Reset with every input high
        rst          = 1'b1;
        sensorIn     = 1'b1;
        walkButtonIn = 1'b1;
        walkAck      = 1'b1;
        tickRestart  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step(1);
            check("rst_sensor", Sensor, 1'b0);
            check("rst_walk_req", walkReq, 1'b0);
            check("rst_sec_tick", secTick, 1'b0);
        end
        rst          = 1'b0;
        sensorIn     = 1'b0;
        walkButtonIn = 1'b0;
        walkAck      = 1'b0;
        tickRestart  = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            check("first_ticks", secTick, (i == 10 || i == 20));
        end

        // Bouncy press: walkReq 7 cycles after the stable level starts
        walkButtonIn = 1'b1; step(1);
        walkButtonIn = 1'b0; step(1);
        walkButtonIn = 1'b1; step(1);
        walkButtonIn = 1'b0; step(1);
        walkButtonIn = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step(1);
            check("bounce_walk_req", walkReq, (i == 7));
        end
        step(50);
        check("hold_single", walkReq, 1'b1);
        walkButtonIn = 1'b0;
        step(10);
        walkAck = 1'b1; step(1); walkAck = 1'b0;
        check("ack_clear", walkReq, 1'b0);

        // Three-cycle pulse is filtered out
        walkButtonIn = 1'b1; step(3); walkButtonIn = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            check("short_pulse", walkReq, 1'b0);
        end

        // Fresh rise coinciding with an ack while walkReq is pending: set wins
        walkButtonIn = 1'b1; step(7);
        check("press2", walkReq, 1'b1);
        walkButtonIn = 1'b0; step(10);
        walkButtonIn = 1'b1; step(6);
        walkAck = 1'b1; step(1); walkAck = 1'b0;
        check("ack_collision", walkReq, 1'b1);
        walkAck = 1'b1; step(1); walkAck = 1'b0;
        check("ack_after_collision", walkReq, 1'b0);
        walkButtonIn = 1'b0; step(10);

        // Sensor rise, glitch rejection, fall, and a 5-cycle assertion
        sensorIn = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step(1);
            check("sensor_rise", Sensor, (i == 6));
        end
        sensorIn = 1'b0; step(2); sensorIn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            check("sensor_glitch", Sensor, 1'b1);
        end
        sensorIn = 1'b0; step(10);
        check("sensor_fall", Sensor, 1'b0);
        sensorIn = 1'b1; step(5); sensorIn = 1'b0; step(1);
        check("sensor_5cyc", Sensor, 1'b1);
        step(10);
        check("sensor_5cyc_fall", Sensor, 1'b0);

        // Restart at tcnt=5
        wait_tick();
        step(5);
        tickRestart = 1'b1; step(1); tickRestart = 1'b0;
        check("restart5_edge", secTick, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            step(1);
            check("restart5_tick", secTick, (i == 10));
        end
        // Restart at terminal count: that period's tick is suppressed
        step(9);
        tickRestart = 1'b1; step(1); tickRestart = 1'b0;
        check("restart9_suppressed", secTick, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            step(1);
            check("restart9_tick", secTick, (i == 10));
        end
        // Restart while a tick is already high
        tickRestart = 1'b1; step(1); tickRestart = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            check("restart_on_tick", secTick, (i == 10));
        end

        // Mid-operation reset with walkReq pending at tcnt=7
        walkButtonIn = 1'b1; step(7);
        check("press3", walkReq, 1'b1);
        walkButtonIn = 1'b0; step(10);
        wait_tick();
        step(7);
        rst = 1'b1; step(1); rst = 1'b0;
        check("midrst_walk_req", walkReq, 1'b0);
        check("midrst_sec_tick", secTick, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            step(1);
            check("midrst_tick", secTick, (i == 10));
            check("midrst_walk_hold", walkReq, 1'b0);
        end

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
